svm_feature_packer: RTL
=======================

Name: svm_feature_packer

Overview:
- Upstream stage of the combinational red-wine SVM regressor.
- Accepts raw 8-bit feature samples one per beat on a valid/ready stream and quantizes each to the 4-bit activation width.
- Packs 11 features into the 44-bit activation vector that the regressor consumes on its `inp` bus, and holds the vector stable under a valid/ready handshake until the downstream register stage takes it.

Parameters:
- NUM_FEAT, 11, features per vector.
- IN_W, 8, raw sample width (unsigned).
- ACT_W, 4, quantized activation width (unsigned).
- CNT_W, 16, width of the completed-vector counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  raw sample valid.
- s_ready  output  1  packer can accept a sample.
- s_data  input  IN_W  raw unsigned feature sample.
- s_last  input  1  marks final sample of a frame; used only with FEATPACK_FRAME_CHECK_EN.
- m_valid  output  1  packed vector valid.
- m_ready  input  1  downstream accepts vector.
- m_data  output  NUM_FEAT*ACT_W  packed vector; feature i at bits [i*ACT_W+ACT_W-1 : i*ACT_W].
- frame_err  output  1  one-cycle pulse on a malformed frame.
- vec_count  output  CNT_W  number of vectors handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: s_ready=0 while rst_n low, 1 on the first clock after release; m_valid=0; m_data=0; frame_err=0; vec_count=0; feature index=0; state=COLLECT.
- Quantization of each accepted beat: q = (s_data + 2^(IN_W-ACT_W-1)) >> (IN_W-ACT_W).
  - Round half up.
  - Use an IN_W+1 bit intermediate.
  - Saturate q to 2^ACT_W-1.
  - Examples: 0x00→0, 0x07→0, 0x08→1, 0x7F→8, 0xF7→15, 0xF8→15 (saturated), 0xFF→15.
- Accept condition: s_valid && s_ready. The quantized nibble is written into slot idx, then idx increments.
- State COLLECT:
  - s_ready=1, m_valid=0.
  - On accept with idx==NUM_FEAT-1: idx→0, state→HOLD.
- State HOLD:
  - s_ready=0, m_valid=1.
  - m_data is stable and equals the last completed vector.
  - On m_ready: vec_count increments, state→COLLECT.
- Latency: m_valid rises the cycle after the 11th sample is accepted.
- Throughput: at most one vector per NUM_FEAT+1 cycles with m_ready held high.
- m_data is registered and is not updated in place during COLLECT. Slots are written into a shadow register, which is copied to m_data on the HOLD entry edge. Previous contents remain visible while m_valid=0.
- s_valid dropping mid-frame: the packer waits with no timeout, and idx is retained.
- m_ready asserted while m_valid=0: ignored.
- vec_count wrap: 0xFFFF→0x0000 with no flag.
- rst_n asserted mid-frame or mid-HOLD: all state clears immediately, the partial or held vector is discarded, and m_valid drops asynchronously.

Optional Feature:
- Macro FEATPACK_FRAME_CHECK_EN.
- Defined:
  - Short frame: s_last accepted with idx<NUM_FEAT-1. The beat is discarded, idx→0, frame_err pulses next cycle, state stays COLLECT, and no vector is produced.
  - Long frame: 11th beat accepted with s_last=0. frame_err pulses, state→DRAIN with s_ready=1, and beats are consumed and discarded until s_last is accepted, then state→COLLECT. No vector is produced for that frame.
  - Well-formed frame: 11th beat accepted with s_last=1 behaves as the base design.
- Undefined:
  - s_last is ignored and frames are delimited purely by count.
  - DRAIN does not exist.
  - frame_err is tied 0.

Test Plan:
- Reset then 11 beats 0x10,0x20,…,0xB0 back-to-back, m_ready=1 → m_valid high 1 cycle after beat 11; m_data nibbles 1,2,…,11 in slots 0..10; vec_count=1.
- Rounding/saturation: beats 0x07,0x08,0x7F,0xF7,0xF8,0xFF, then five beats of 0x00 → slots 0,1,8,15,15,15,0,0,0,0,0.
- Back-pressure: complete a vector, hold m_ready=0 for 20 cycles while s_valid=1 → s_ready=0 and m_data unchanged throughout; m_ready=1 → handoff, s_ready=1 the next cycle.
- Reset mid-frame: after 6 beats pull rst_n low for 1 cycle, then send 11 beats of 0xFF → exactly one vector with all nibbles 15; vec_count=1.
- With FEATPACK_FRAME_CHECK_EN: 5 beats with s_last on beat 5 → frame_err pulse, no m_valid. Then 13 beats with s_last on beat 13 → frame_err pulse, no m_valid. Then a well-formed 11-beat frame → one vector.
- vec_count wrap: preload via 65536 handoffs (or force) → reads 0 after the 65536th handoff.

Source files
------------

// File: rtl/svm_feature_packer.sv
// ============================================================================
// svm_feature_packer
// ----------------------------------------------------------------------------
// Upstream stage of the combinational red-wine SVM regressor. Raw 8-bit
// feature samples arrive one per beat on a valid/ready stream. Each sample is
// quantized (round half up, saturate) to a 4-bit activation. Eleven
// activations are packed into the 44-bit vector that the regressor reads on
// its `inp` bus. The vector is held stable until the downstream register
// stage takes it.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    raw sample valid
//   s_ready    packer can accept a sample (low during reset and while holding)
//   s_data     raw unsigned feature sample [IN_W-1:0]
//   s_last     final sample of a frame (only meaningful with frame checking)
//   m_valid    packed vector valid
//   m_ready    downstream accepts the vector
//   m_data     packed vector; feature i at bits [i*ACT_W +: ACT_W]
//   frame_err  one-cycle pulse on a malformed frame
//   vec_count  number of vectors handed off, wraps modulo 2^CNT_W
//
// Build option:
//   FEATPACK_FRAME_CHECK_EN  When defined, s_last is checked against the
//                            feature count. Short frames are dropped. Long
//                            frames are drained up to s_last. Both cases pulse
//                            frame_err. When undefined, s_last is ignored,
//                            frames are delimited by count only, and frame_err
//                            is tied low.
// ============================================================================
module svm_feature_packer #(
    parameter int NUM_FEAT = 11,
    parameter int IN_W     = 8,
    parameter int ACT_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_W-1:0]           s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NUM_FEAT*ACT_W-1:0] m_data,
    output logic                      frame_err,
    output logic [CNT_W-1:0]          vec_count
);

    localparam int VEC_W = NUM_FEAT * ACT_W;
    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam int SHIFT = IN_W - ACT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic [IN_W:0]    HALF_LSB = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic [IN_W:0]    ACT_MAX  = (IN_W+1)'(2 ** ACT_W - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1
`ifdef FEATPACK_FRAME_CHECK_EN
        ,
        DRAIN   = 2'd2
`endif
    } state_t;

    // Adds half an output LSB and drops the low bits. The extra top bit keeps
    // the carry out of 0xF8..0xFF, so saturation can see it.
    function automatic logic [IN_W:0] round_half_up(input logic [IN_W-1:0] d);
        logic [IN_W:0] sum;
        sum = {1'b0, d} + HALF_LSB;
        return sum >> SHIFT;
    endfunction

    // Clamps a rounded value to the activation range.
    function automatic logic [ACT_W-1:0] saturate_act(input logic [IN_W:0] r);
        logic [ACT_W-1:0] res;
        if (r > ACT_MAX) begin
            res = '1;
        end else begin
            res = r[ACT_W-1:0];
        end
        return res;
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [VEC_W-1:0]   shadow;
    logic [VEC_W-1:0]   shadow_nxt;
    logic [ACT_W-1:0]   beat_q;
    logic               ready_en;
    logic               accept;
    logic               wr_slot;
    logic               load_vec;
    logic               handoff;

    // ready_en keeps s_ready low while reset is asserted. It lets s_ready rise
    // only on the first clock after reset is released.
`ifdef FEATPACK_FRAME_CHECK_EN
    assign s_ready = ready_en && ((state == COLLECT) || (state == DRAIN));
`else
    assign s_ready = ready_en && (state == COLLECT);
`endif
    assign m_valid = (state == HOLD);
    assign accept  = s_valid && s_ready;
    assign beat_q  = saturate_act(round_half_up(s_data));

    // The final nibble is merged combinationally, so the HOLD-entry copy to
    // m_data already contains the 11th feature.
    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[idx*ACT_W +: ACT_W] = beat_q;
    end

`ifdef FEATPACK_FRAME_CHECK_EN
    logic err_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_slot   = 1'b0;
        load_vec  = 1'b0;
        handoff   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (s_last) begin
                            wr_slot   = 1'b1;
                            load_vec  = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            // Too many beats: drop this frame and discard up to s_last.
                            err_nxt   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (s_last) begin
                        // Frame ended early: discard the partial vector.
                        idx_nxt = '0;
                        err_nxt = 1'b1;
                    end else begin
                        wr_slot = 1'b1;
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    handoff   = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_nxt;
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign frame_err   = 1'b0;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_slot   = 1'b0;
        load_vec  = 1'b0;
        handoff   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    wr_slot = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        load_vec  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    handoff   = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- collect stage -> output register boundary ----
    // m_data changes only on the edge that enters HOLD. The previous vector
    // therefore stays visible while the next frame is being collected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            idx       <= '0;
            shadow    <= '0;
            m_data    <= '0;
            vec_count <= '0;
        end else begin
            ready_en <= 1'b1;
            idx      <= idx_nxt;
            if (wr_slot) begin
                shadow <= shadow_nxt;
            end
            if (load_vec) begin
                m_data <= shadow_nxt;
            end
            if (handoff) begin
                vec_count <= vec_count + CNT_W'(1);
            end
        end
    end

endmodule
